// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, data and memory-side signals of the shared memory port arbiter.
// Latency: none (signal bundle only).
// Backpressure: mem_ready stalls issue; requesters hold req until their rvalid pulse.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch requester (read-only)
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // MEM-stage load/store requester
  logic              d_req;
  logic              d_we;
  logic [3:0]        d_be;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  // Single-ported memory
  logic              mem_req;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side: serves both requesters, drives the memory.
  modport slave (
    input  if_req, if_addr,
    output if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_rvalid, d_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  // Environment side: requesters plus the memory itself.
  modport master (
    output if_req, if_addr,
    input  if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_rvalid, d_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch and load/store, data-first with a fetch starvation limit.
// Latency: req at cycle 0 -> mem_req at 1 -> rvalid at 3 minimum; empty store (be=0) answers at cycle 1.
// Backpressure: mem_req and its fields are held stable until mem_ready; one transaction outstanding at a time.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int              CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            r_state;
  logic              r_owner;      // 1 = data requester, 0 = fetch
  logic              r_store;      // granted data access is a store (rdata forced to 0)
  logic [CNT_W-1:0]  r_starve_cnt;

  logic              r_mem_req;
  logic              r_mem_we;
  logic [3:0]        r_mem_be;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic              r_d_rvalid;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_any_req;
  logic              w_pick_data;
  logic              w_empty_store;

  // Arbitration decision: data wins a tie unless fetch has been passed over STARVE_LIMIT times.
  always_comb begin
    w_any_req     = bus.if_req | bus.d_req;
    w_pick_data   = bus.d_req & (~bus.if_req | (r_starve_cnt != LIMIT));
    w_empty_store = bus.d_we & (bus.d_be == 4'b0000);
  end

  // Transaction FSM with all outputs registered; rvalid/rdata default low so RESP is a 1-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_owner      <= 1'b0;
      r_store      <= 1'b0;
      r_starve_cnt <= '0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_be     <= 4'b0000;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_d_rvalid   <= 1'b0;
      r_d_rdata    <= '0;
    end else begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rvalid  <= 1'b0;
      r_d_rdata   <= '0;
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_pick_data;
            if (w_pick_data) begin
              // Each data grant over a waiting fetch moves fetch closer to being forced.
              if (bus.if_req) begin
                if (r_starve_cnt != LIMIT) r_starve_cnt <= r_starve_cnt + 1'b1;
              end else begin
                r_starve_cnt <= '0;
              end
              r_store <= bus.d_we;
              if (w_empty_store) begin
                // Nothing to write: acknowledge without touching memory.
                r_d_rvalid <= 1'b1;
                r_state    <= RESP;
              end else begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= bus.d_we;
                r_mem_be    <= bus.d_be;
                r_mem_addr  <= bus.d_addr;
                r_mem_wdata <= bus.d_wdata;
                r_state     <= ISSUE;
              end
            end else begin
              r_starve_cnt <= '0;
              r_store      <= 1'b0;
              r_mem_req    <= 1'b1;
              r_mem_we     <= 1'b0;
              r_mem_be     <= 4'b1111;
              r_mem_addr   <= bus.if_addr;
              r_mem_wdata  <= '0;
              r_state      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'b0000;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            if (r_owner) begin
              r_d_rvalid <= 1'b1;
              r_d_rdata  <= r_store ? '0 : bus.mem_rdata;
            end else begin
              r_if_rvalid <= 1'b1;
              r_if_rdata  <= bus.mem_rdata;
            end
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rvalid  = r_d_rvalid;
  assign bus.d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Purpose: directed bench for mem_port_arbiter: load, tie-break, starvation, backpressure, empty store, reset.
// Latency: expects rvalid 3 cycles after req with an immediate memory, 1 cycle for an empty store.
// Backpressure: holds mem_ready low to check the issued request stays stable.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .STARVE_LIMIT(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle; inputs driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.if_req     = 1'b0;
    bus.if_addr    = '0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_be       = 4'h0;
    bus.d_addr     = '0;
    bus.d_wdata    = '0;
    bus.mem_ready  = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    do_reset();
    if (bus.mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %0b want 0", bus.mem_req); n_fail++; end
    n_tests++;
    if (bus.mem_be !== 4'h0) begin $display("FAIL reset_mem_be: got %0h want 0", bus.mem_be); n_fail++; end
    n_tests++;
    if (bus.mem_addr !== 32'h0) begin $display("FAIL reset_mem_addr: got %0h want 0", bus.mem_addr); n_fail++; end
    n_tests++;
    if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      $display("FAIL reset_rvalid: got if=%0b d=%0b want 0 0", bus.if_rvalid, bus.d_rvalid); n_fail++;
    end
    n_tests++;
    if (bus.d_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin
      $display("FAIL reset_rdata: got if=%0h d=%0h want 0 0", bus.if_rdata, bus.d_rdata); n_fail++;
    end
    n_tests++;
  endtask

  task automatic test_load();
    // cycle 0
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100; bus.d_be = 4'hF;
    bus.mem_ready = 1'b1;
    tick(); // cycle 1: ISSUE
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF) begin
      $display("FAIL load_issue: got req=%0b addr=%0h we=%0b be=%0h want 1 100 0 f",
               bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be); n_fail++;
    end
    n_tests++;
    tick(); // cycle 2: WAIT
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    if (bus.mem_req !== 1'b0) begin $display("FAIL load_wait_req: got %0b want 0", bus.mem_req); n_fail++; end
    n_tests++;
    if (bus.d_rvalid !== 1'b0) begin $display("FAIL load_early_rvalid: got %0b want 0", bus.d_rvalid); n_fail++; end
    n_tests++;
    tick(); // cycle 3: RESP
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
      $display("FAIL load_resp: got rvalid=%0b rdata=%0h want 1 deadbeef", bus.d_rvalid, bus.d_rdata); n_fail++;
    end
    n_tests++;
    if (bus.if_rvalid !== 1'b0) begin $display("FAIL load_if_rvalid: got %0b want 0", bus.if_rvalid); n_fail++; end
    n_tests++;
    tick(); // cycle 4: IDLE, requester has dropped req
    bus.d_req = 1'b0;
    if (bus.d_rvalid !== 1'b0 || bus.d_rdata !== 32'h0) begin
      $display("FAIL load_pulse_len: got rvalid=%0b rdata=%0h want 0 0", bus.d_rvalid, bus.d_rdata); n_fail++;
    end
    n_tests++;
    tick();
  endtask

  task automatic test_simultaneous();
    bus.if_req = 1'b1; bus.if_addr = 32'h200;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'h5; bus.d_addr = 32'h300; bus.d_wdata = 32'h12345678;
    bus.mem_ready = 1'b1;
    tick(); // cycle 1: data issued
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 32'h300 ||
        bus.mem_be !== 4'h5 || bus.mem_wdata !== 32'h12345678) begin
      $display("FAIL sim_data_first: got req=%0b we=%0b addr=%0h be=%0h wdata=%0h want 1 1 300 5 12345678",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata); n_fail++;
    end
    n_tests++;
    tick(); // cycle 2
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hAAAA5555;
    tick(); // cycle 3: store ack, rdata forced to 0
    bus.mem_rvalid = 1'b0;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.if_rvalid !== 1'b0) begin
      $display("FAIL sim_store_ack: got d_rvalid=%0b d_rdata=%0h if_rvalid=%0b want 1 0 0",
               bus.d_rvalid, bus.d_rdata, bus.if_rvalid); n_fail++;
    end
    n_tests++;
    tick(); // cycle 4: IDLE sees only fetch
    bus.d_req = 1'b0;
    tick(); // cycle 5: fetch issued
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'hF || bus.mem_addr !== 32'h200) begin
      $display("FAIL sim_fetch_next: got req=%0b we=%0b be=%0h addr=%0h want 1 0 f 200",
               bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr); n_fail++;
    end
    n_tests++;
    tick(); // cycle 6
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    tick(); // cycle 7
    bus.mem_rvalid = 1'b0;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hCAFEF00D || bus.d_rvalid !== 1'b0) begin
      $display("FAIL sim_fetch_resp: got if_rvalid=%0b if_rdata=%0h d_rvalid=%0b want 1 cafef00d 0",
               bus.if_rvalid, bus.if_rdata, bus.d_rvalid); n_fail++;
    end
    n_tests++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_starvation();
    int   grants[$];
    logic prev_req;
    clear_inputs();
    do_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h700;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h3; bus.d_addr = 32'h800;
    bus.mem_ready = 1'b1;
    prev_req = 1'b0;
    for (int c = 0; c < 200 && grants.size() < 10; c++) begin
      tick();
      bus.mem_rvalid = prev_req;
      bus.mem_rdata  = 32'h1;
      prev_req = bus.mem_req;
      if (bus.mem_req === 1'b1) grants.push_back((bus.mem_be == 4'hF) ? 1 : 0);
    end
    if (grants.size() != 10) begin
      $display("FAIL starve_grant_count: got %0d want 10", grants.size()); n_fail++;
    end
    n_tests++;
    for (int i = 0; i < grants.size(); i++) begin
      if (grants[i] != ((i % 5 == 4) ? 1 : 0)) begin
        $display("FAIL starve_grant_%0d: got fetch=%0d want %0d", i, grants[i], (i % 5 == 4) ? 1 : 0); n_fail++;
      end
      n_tests++;
    end
    clear_inputs();
    do_reset();
  endtask

  task automatic test_backpressure();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h400; bus.d_wdata = 32'h000055AA;
    bus.mem_ready = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick(); // cycles 1..5: stalled in ISSUE
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h400 || bus.mem_we !== 1'b1 ||
          bus.mem_be !== 4'hF || bus.mem_wdata !== 32'h000055AA) begin
        $display("FAIL bp_stable_c%0d: got req=%0b addr=%0h we=%0b be=%0h wdata=%0h want 1 400 1 f 55aa",
                 c, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_be, bus.mem_wdata); n_fail++;
      end
      n_tests++;
    end
    tick(); // cycle 6: accepted
    bus.mem_ready = 1'b1;
    tick(); // cycle 7: WAIT
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1;
    if (bus.mem_req !== 1'b0 || bus.d_rvalid !== 1'b0) begin
      $display("FAIL bp_c7: got mem_req=%0b d_rvalid=%0b want 0 0", bus.mem_req, bus.d_rvalid); n_fail++;
    end
    n_tests++;
    tick(); // cycle 8
    bus.mem_rvalid = 1'b0;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0) begin
      $display("FAIL bp_resp_c8: got rvalid=%0b rdata=%0h want 1 0", bus.d_rvalid, bus.d_rdata); n_fail++;
    end
    n_tests++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_empty_store();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_be = 4'h0; bus.d_addr = 32'h900; bus.d_wdata = 32'hFFFFFFFF;
    bus.mem_ready = 1'b1;
    tick(); // cycle 1
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.mem_req !== 1'b0) begin
      $display("FAIL empty_store_c1: got rvalid=%0b rdata=%0h mem_req=%0b want 1 0 0",
               bus.d_rvalid, bus.d_rdata, bus.mem_req); n_fail++;
    end
    n_tests++;
    tick(); // cycle 2
    bus.d_req = 1'b0;
    if (bus.d_rvalid !== 1'b0 || bus.mem_req !== 1'b0) begin
      $display("FAIL empty_store_c2: got rvalid=%0b mem_req=%0b want 0 0", bus.d_rvalid, bus.mem_req); n_fail++;
    end
    n_tests++;
    tick();
    clear_inputs();
    tick();
  endtask

  task automatic test_reset_in_wait();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h500;
    bus.mem_ready = 1'b1;
    tick(); // cycle 1: ISSUE
    tick(); // cycle 2: WAIT, reset asserted
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    tick(); // cycle 3: back in IDLE
    reset = 1'b0;
    bus.d_req = 1'b0;
    if (bus.mem_req !== 1'b0 || bus.d_rvalid !== 1'b0 || bus.mem_addr !== 32'h0) begin
      $display("FAIL rst_wait_c3: got mem_req=%0b d_rvalid=%0b addr=%0h want 0 0 0",
               bus.mem_req, bus.d_rvalid, bus.mem_addr); n_fail++;
    end
    n_tests++;
    tick(); // cycle 4: late response
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h00000BAD;
    tick(); // cycle 5
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
    if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.mem_req !== 1'b0 || bus.d_rdata !== 32'h0) begin
      $display("FAIL rst_late_rvalid: got d_rvalid=%0b if_rvalid=%0b mem_req=%0b d_rdata=%0h want 0 0 0 0",
               bus.d_rvalid, bus.if_rvalid, bus.mem_req, bus.d_rdata); n_fail++;
    end
    n_tests++;
    // New request served normally
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'hF; bus.d_addr = 32'h600;
    bus.mem_ready = 1'b1;
    tick();
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h600) begin
      $display("FAIL rst_next_issue: got req=%0b addr=%0h want 1 600", bus.mem_req, bus.mem_addr); n_fail++;
    end
    n_tests++;
    tick();
    bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h0000600D;
    tick();
    bus.mem_rvalid = 1'b0;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0000600D) begin
      $display("FAIL rst_next_resp: got rvalid=%0b rdata=%0h want 1 600d", bus.d_rvalid, bus.d_rdata); n_fail++;
    end
    n_tests++;
    tick();
    clear_inputs();
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    clear_inputs();
    test_reset();
    test_load();
    test_simultaneous();
    test_starvation();
    test_backpressure();
    test_empty_store();
    test_reset_in_wait();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
